// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: shares one memory port between core LSU and
// the debug bridge, with a key-sequence lock that gates all debug accesses.
//
// Ports:
//   clk, reset                  clock / synchronous active-high reset
//   core_* / dbg_*              request side: req, we, width, addr, wdata
//                               response side: gnt (comb), rvalid, rdata
//   dbg_err                     qualifies dbg_rvalid: access was denied
//   key_valid, key_data, relock lock FSM controls
//   mem_*                       single-port data memory interface
//   debug_unlocked              lock FSM is in UNLOCKED
//   violation_count             saturating count of denied debug requests
module dmem_access_ctrl #(
    parameter logic [31:0] KEY0    = 32'hA5A5_5A5A,
    parameter logic [31:0] KEY1    = 32'h3C3C_C3C3,
    parameter int          TIMEOUT = 16,
    parameter int          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [2:0]       core_width,
    input  logic [31:0]      core_addr,
    input  logic [31:0]      core_wdata,
    output logic             core_gnt,
    output logic             core_rvalid,
    output logic [31:0]      core_rdata,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [2:0]       dbg_width,
    input  logic [31:0]      dbg_addr,
    input  logic [31:0]      dbg_wdata,
    output logic             dbg_gnt,
    output logic             dbg_rvalid,
    output logic [31:0]      dbg_rdata,
    output logic             dbg_err,
    input  logic             key_valid,
    input  logic [31:0]      key_data,
    input  logic             relock,
    output logic             mem_we,
    output logic [2:0]       mem_width,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             debug_unlocked,
    output logic [CNT_W-1:0] violation_count
);

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_KEY_WAIT = 2'd1,
        S_UNLOCKED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_next_timer;

    logic              r_last_dbg;
    logic              r_core_rvalid;
    logic [31:0]       r_core_rdata;
    logic              r_dbg_rvalid;
    logic              r_dbg_err;
    logic [31:0]       r_dbg_rdata;
    logic [CNT_W-1:0]  r_viol;

    logic              w_unlocked;
    logic              w_dbg_denied;
    logic              w_dbg_mem;
    logic              w_core_gnt;
    logic              w_dbg_mem_gnt;

    // ---------------- lock FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOCKED;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_timer = '0;
        unique case (r_state)
            S_LOCKED: begin
                if (key_valid && key_data == KEY0) begin
                    w_next_state = S_KEY_WAIT;
                end
            end
            S_KEY_WAIT: begin
                // A key strobe always ends the wait, right or wrong.
                if (key_valid) begin
                    w_next_state = (key_data == KEY1) ? S_UNLOCKED : S_LOCKED;
                end else if (r_timer == TLAST) begin
                    w_next_state = S_LOCKED;
                end else begin
                    w_next_timer = r_timer + 1'b1;
                end
            end
            S_UNLOCKED: begin
                w_next_state = S_UNLOCKED;
            end
            default: begin
                w_next_state = S_LOCKED;
            end
        endcase
        if (relock) begin
            w_next_state = S_LOCKED;
            w_next_timer = '0;
        end
    end

    assign w_unlocked     = (r_state == S_UNLOCKED);
    assign debug_unlocked = w_unlocked;

    // ---------------- arbitration ----------------
    // Denied debug requests are acknowledged without touching memory, so
    // they never compete with the core.
    assign w_dbg_denied  = dbg_req & ~w_unlocked;
    assign w_dbg_mem     = dbg_req & w_unlocked;
    assign w_core_gnt    = core_req & (~w_dbg_mem | r_last_dbg);
    assign w_dbg_mem_gnt = w_dbg_mem & (~core_req | ~r_last_dbg);

    assign core_gnt = w_core_gnt;
    assign dbg_gnt  = w_dbg_mem_gnt | w_dbg_denied;

    always_comb begin
        mem_we    = 1'b0;
        mem_width = 3'b010;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_core_gnt) begin
            mem_we    = core_we;
            mem_width = core_width;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (w_dbg_mem_gnt) begin
            mem_we    = dbg_we;
            mem_width = dbg_width;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // ---------------- pointer, responses, counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_dbg    <= 1'b1;
            r_core_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_dbg_rvalid  <= 1'b0;
            r_dbg_err     <= 1'b0;
            r_dbg_rdata   <= '0;
            r_viol        <= '0;
        end else begin
            if (w_core_gnt) begin
                r_last_dbg <= 1'b0;
            end else if (w_dbg_mem_gnt) begin
                r_last_dbg <= 1'b1;
            end
            r_core_rvalid <= w_core_gnt;
            if (w_core_gnt) begin
                r_core_rdata <= mem_rdata;
            end
            r_dbg_rvalid <= w_dbg_mem_gnt | w_dbg_denied;
            r_dbg_err    <= w_dbg_denied;
            if (w_dbg_denied) begin
                r_dbg_rdata <= '0;
            end else if (w_dbg_mem_gnt) begin
                r_dbg_rdata <= mem_rdata;
            end
            if (w_dbg_denied && r_viol != {CNT_W{1'b1}}) begin
                r_viol <= r_viol + 1'b1;
            end
        end
    end

    assign core_rvalid     = r_core_rvalid;
    assign core_rdata      = r_core_rdata;
    assign dbg_rvalid      = r_dbg_rvalid;
    assign dbg_err         = r_dbg_err;
    assign dbg_rdata       = r_dbg_rdata;
    assign violation_count = r_viol;

endmodule
